// File: rtl/encoder_pkg.sv
// Shared types and constants for the sequential scan encoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package encoder_pkg;

  // Default number of input lines (power of 2, >= 2).
  localparam int ENC_N_IN = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } enc_state_t;

  // Output code width for a given number of input lines.
  function automatic int code_w(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer, one independent flop pair per bit.
// Latency: 2 cycles from d to q.
// Backpressure: none; free-running.
//
// Ports:
//   clk   system clock
//   reset synchronous active-high reset, clears both stages
//   d     asynchronous input bits
//   q     synchronized bits
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/scan_encoder_16to4.sv
// Sequential priority encoder: snapshots N_IN lines on start and reports the lowest set index.
// Latency: valid rises N_IN+1 edges after the start edge, independent of data.
// Backpressure: result held in HOLD until ack; start while busy is dropped, not queued.
//
// Ports:
//   clk    system clock
//   reset  synchronous active-high reset (dominates en/start/ack)
//   en     block enable; low aborts any scan or held result
//   start  scan request, sampled only in IDLE with en=1
//   w      input lines; w[i]=1 maps to code i
//   ack    consumer accepts result, sampled only in HOLD
//   code   index of lowest active bit (0 when none)
//   valid  result stable and presentable
//   none   snapshot was all-zero (qualified by valid)
//   multi  snapshot had two or more bits set (qualified by valid)
//   busy   high in SCAN and HOLD
//
// Build option ENC_SYNC_EN: route w through a 2-flop synchronizer before the
// snapshot register (snapshot then reflects w two cycles before start).
module scan_encoder_16to4
  import encoder_pkg::*;
#(
  parameter int N_IN = ENC_N_IN
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    start,
  input  logic [N_IN-1:0]         w,
  input  logic                    ack,
  output logic [code_w(N_IN)-1:0] code,
  output logic                    valid,
  output logic                    none,
  output logic                    multi,
  output logic                    busy
);

  localparam int CODE_W = code_w(N_IN);
  localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(N_IN - 1);

  enc_state_t        state, state_nxt;
  logic [N_IN-1:0]   snap, snap_nxt;
  logic [CODE_W-1:0] idx, idx_nxt;
  logic              found, found_nxt;
  logic              last, last_nxt;
  logic [CODE_W-1:0] code_nxt;
  logic              valid_nxt, none_nxt, multi_nxt;
  logic [N_IN-1:0]   w_s;

`ifdef ENC_SYNC_EN
  sync_2ff #(.W(N_IN)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (w),
    .q     (w_s)
  );
`else
  assign w_s = w;
`endif

  assign busy = (state != IDLE);

  always_comb begin
    state_nxt = state;
    snap_nxt  = snap;
    idx_nxt   = idx;
    found_nxt = found;
    last_nxt  = last;
    code_nxt  = code;
    valid_nxt = valid;
    none_nxt  = none;
    multi_nxt = multi;

    if (!en) begin
      // Abort: discard any in-flight or unacknowledged result.
      if (state != IDLE) begin
        state_nxt = IDLE;
        valid_nxt = 1'b0;
        code_nxt  = '0;
        none_nxt  = 1'b0;
        multi_nxt = 1'b0;
        found_nxt = 1'b0;
        last_nxt  = 1'b0;
        idx_nxt   = '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            snap_nxt  = w_s;
            idx_nxt   = '0;
            found_nxt = 1'b0;
            last_nxt  = 1'b0;
            code_nxt  = '0;
            none_nxt  = 1'b0;
            multi_nxt = 1'b0;
            state_nxt = SCAN;
          end
        end
        SCAN: begin
          if (last) begin
            // All N_IN bits examined on the previous edges; publish the result.
            // This extra cycle keeps latency fixed at N_IN+1.
            state_nxt = HOLD;
            valid_nxt = 1'b1;
            none_nxt  = ~found;
          end else begin
            if (snap[idx]) begin
              if (!found) begin
                code_nxt  = idx;
                found_nxt = 1'b1;
              end else begin
                multi_nxt = 1'b1;
              end
            end
            // idx stops at the top index rather than wrapping.
            if (idx == LAST_IDX) begin
              last_nxt = 1'b1;
            end else begin
              idx_nxt = idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (ack) begin
            valid_nxt = 1'b0;
            state_nxt = IDLE;
          end
        end
        default: begin
          state_nxt = IDLE;
          valid_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      snap  <= '0;
      idx   <= '0;
      found <= 1'b0;
      last  <= 1'b0;
      code  <= '0;
      valid <= 1'b0;
      none  <= 1'b0;
      multi <= 1'b0;
    end else begin
      state <= state_nxt;
      snap  <= snap_nxt;
      idx   <= idx_nxt;
      found <= found_nxt;
      last  <= last_nxt;
      code  <= code_nxt;
      valid <= valid_nxt;
      none  <= none_nxt;
      multi <= multi_nxt;
    end
  end

endmodule

// File: tb/tb_scan_encoder_16to4.sv
module tb_scan_encoder_16to4;

  typedef struct packed {
    logic [3:0] code;
    logic       none;
    logic       multi;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        en;
  logic        start;
  logic [15:0] w;
  logic        ack;
  logic [3:0]  code;
  logic        valid;
  logic        none;
  logic        multi;
  logic        busy;

  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   popped = 0;
  exp_t sb_q[$];
  exp_t cur;
  logic prev_valid = 1'b0;

  scan_encoder_16to4 dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .start (start),
    .w     (w),
    .ack   (ack),
    .code  (code),
    .valid (valid),
    .none  (none),
    .multi (multi),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected result per rising valid, then checks it stays held.
  always @(negedge clk) begin
    if (valid === 1'b1 && prev_valid !== 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got code=%0d none=%0b multi=%0b, expected no result",
                 code, none, multi);
      end else begin
        cur = sb_q.pop_front();
        popped++;
        chk("result_code",  {28'd0, code},  {28'd0, cur.code});
        chk("result_none",  {31'd0, none},  {31'd0, cur.none});
        chk("result_multi", {31'd0, multi}, {31'd0, cur.multi});
      end
    end else if (valid === 1'b1) begin
      chk("hold_code",  {28'd0, code},  {28'd0, cur.code});
      chk("hold_none",  {31'd0, none},  {31'd0, cur.none});
      chk("hold_multi", {31'd0, multi}, {31'd0, cur.multi});
    end
    prev_valid = valid;
  end

  task automatic push_exp(input logic [3:0] c, input logic n, input logic m);
    exp_t e;
    e.code  = c;
    e.none  = n;
    e.multi = m;
    sb_q.push_back(e);
    pushed++;
  endtask

  // Called right after the negedge following the start edge; counts edges to valid.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    if (valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL valid_timeout: got valid=%0b after %0d cycles, expected 1", valid, cyc);
    end
  endtask

  // Present w well before start so the optional synchronizer has settled.
  task automatic issue_start(input logic [15:0] wv);
    @(negedge clk);
    w = wv;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("valid_after_ack", {31'd0, valid}, 32'd0);
    chk("busy_after_ack",  {31'd0, busy},  32'd0);
  endtask

  task automatic do_scan(input logic [15:0] wv, input logic [3:0] c,
                         input logic n, input logic m, input int hold);
    int cyc;
    push_exp(c, n, m);
    issue_start(wv);
    chk("busy_in_scan", {31'd0, busy}, 32'd1);
    wait_valid(cyc);
    chk("latency", cyc, 32'd17);
    repeat (hold) @(negedge clk);
    chk("valid_held", {31'd0, valid}, 32'd1);
    do_ack();
  endtask

  initial begin
    int cyc;
    reset = 1'b1;
    en    = 1'b1;
    start = 1'b0;
    ack   = 1'b0;
    w     = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_busy",  {31'd0, busy},  32'd0);
    chk("rst_code",  {28'd0, code},  32'd0);
    chk("rst_none",  {31'd0, none},  32'd0);
    chk("rst_multi", {31'd0, multi}, 32'd0);
    reset = 1'b0;

    // Reset mid-scan, with start also asserted to show reset dominates.
    issue_start(16'h0010);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    chk("midrst_busy",  {31'd0, busy},  32'd0);
    chk("midrst_valid", {31'd0, valid}, 32'd0);
    chk("midrst_code",  {28'd0, code},  32'd0);
    chk("midrst_multi", {31'd0, multi}, 32'd0);
    chk("midrst_none",  {31'd0, none},  32'd0);

    // Main function across patterns.
    do_scan(16'h0020, 4'd5,  1'b0, 1'b0, 3);
    do_scan(16'h8001, 4'd0,  1'b0, 1'b1, 0);
    do_scan(16'h8000, 4'd15, 1'b0, 1'b0, 1);
    do_scan(16'hFFFF, 4'd0,  1'b0, 1'b1, 0);
    do_scan(16'h0000, 4'd0,  1'b1, 1'b0, 2);
    do_scan(16'h0600, 4'd9,  1'b0, 1'b1, 0);

    // Snapshot isolation plus start pulses ignored during SCAN and HOLD.
    push_exp(4'd8, 1'b0, 1'b0);
    issue_start(16'h0100);
    repeat (2) @(negedge clk);
    w = 16'h0001;
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hold_valid_after_start", {31'd0, valid}, 32'd1);
    do_ack();
    repeat (25) @(negedge clk);
    chk("no_queued_start_busy", {31'd0, busy}, 32'd0);

    // en=0 during HOLD discards the result without ack.
    push_exp(4'd3, 1'b0, 1'b0);
    issue_start(16'h0008);
    wait_valid(cyc);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_valid", {31'd0, valid}, 32'd0);
    chk("en_off_busy",  {31'd0, busy},  32'd0);
    chk("en_off_code",  {28'd0, code},  32'd0);

    // start with en=0 is ignored.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_en_off_busy", {31'd0, busy}, 32'd0);
    en = 1'b1;

`ifdef ENC_SYNC_EN
    // w changed one cycle before start: old value captured.
    @(negedge clk);
    w = 16'h0002;
    repeat (4) @(negedge clk);
    w = 16'h0004;
    push_exp(4'd1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    chk("sync_old_latency", cyc, 32'd17);
    do_ack();
    // w changed three cycles before start: new value captured.
    w = 16'h0040;
    push_exp(4'd6, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    do_ack();
`else
    // Direct sampling: w changed in the same cycle as start is captured.
    @(negedge clk);
    w = 16'h0002;
    repeat (3) @(negedge clk);
    w     = 16'h0400;
    start = 1'b1;
    push_exp(4'd10, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_valid(cyc);
    chk("direct_latency", cyc, 32'd17);
    do_ack();
`endif

    repeat (3) @(negedge clk);
    chk("results_seen", popped, pushed);
    chk("queue_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
